// File: rtl/up_dn_cmd_driver.sv
// Command-driven initiator for an up/down counter: turns LOAD/UP/DOWN/HOLD
// commands into load/Up/Down strobes, stopping early at the counter limits.
module up_dn_cmd_driver #(
   parameter int WIDTH = 5,
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_val,
   input  logic [CNT_W-1:0] cmd_rep,
   input  logic             High,
   input  logic             Low,
   output logic [WIDTH-1:0] IN,
   output logic             load,
   output logic             Up,
   output logic             Down,
   output logic             busy,
   output logic             done,
   output logic             sat,
   output logic [CNT_W-1:0] done_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STEP, S_WAIT, S_DONE} state_t;
   typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_HOLD = 2'b11} op_t;

   state_t           state_q, state_nx;
   op_t              op_q, op_nx;
   logic [WIDTH-1:0] val_q, val_nx;
   logic [CNT_W-1:0] rem_q, rem_nx;
   logic [CNT_W-1:0] cnt_q, cnt_nx;
   logic             sat_q, sat_nx;
   logic             limit;
   logic             rdy_c, load_c, up_c, down_c, done_c;

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= OP_LOAD;
         val_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_nx;
         op_q    <= op_nx;
         val_q   <= val_nx;
         rem_q   <= rem_nx;
         cnt_q   <= cnt_nx;
         sat_q   <= sat_nx;
      end
   end

   // Only the flag facing the active direction can stop a STEP command.
   assign limit = (op_q == OP_UP) ? High : Low;

   always_comb begin
      state_nx = state_q;
      op_nx    = op_q;
      val_nx   = val_q;
      rem_nx   = rem_q;
      cnt_nx   = cnt_q;
      sat_nx   = sat_q;
      rdy_c    = 1'b0;
      load_c   = 1'b0;
      up_c     = 1'b0;
      down_c   = 1'b0;
      done_c   = 1'b0;
      case (state_q)
         S_IDLE: begin
            rdy_c = 1'b1;
            if (cmd_valid) begin
               op_nx  = op_t'(cmd_op);
               rem_nx = cmd_rep;
               cnt_nx = '0;
               sat_nx = 1'b0;
               if (op_t'(cmd_op) == OP_LOAD) begin
                  val_nx   = cmd_val;
                  state_nx = S_LOAD;
               end else if (cmd_rep == '0) begin
                  state_nx = S_DONE;
               end else if (op_t'(cmd_op) == OP_HOLD) begin
                  state_nx = S_WAIT;
               end else begin
                  state_nx = S_STEP;
               end
            end
         end
         S_LOAD: begin
            load_c   = 1'b1;
            state_nx = S_DONE;
         end
         S_STEP: begin
            if (limit) begin
               sat_nx   = 1'b1;
               state_nx = S_DONE;
            end else begin
               up_c   = (op_q == OP_UP);
               down_c = (op_q == OP_DOWN);
               rem_nx = rem_q - 1'b1;
               cnt_nx = cnt_q + 1'b1;
               if (rem_q == CNT_W'(1)) state_nx = S_DONE;
            end
         end
         S_WAIT: begin
            rem_nx = rem_q - 1'b1;
            if (rem_q == CNT_W'(1)) state_nx = S_DONE;
         end
         S_DONE: begin
            done_c   = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Reset forces every output low in the same cycle, independent of state.
   assign cmd_ready = rdy_c & ~rst;
   assign load      = load_c & ~rst;
   assign Up        = up_c & ~rst;
   assign Down      = down_c & ~rst;
   assign done      = done_c & ~rst;
   assign sat       = done_c & sat_q & ~rst;
   assign busy      = (state_q != S_IDLE) & ~rst;
   assign IN        = rst ? '0 : val_q;
   assign done_cnt  = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_up_dn_cmd_driver.sv
// Self-checking bench: emulated up/down counter, directed vector table,
// hand-written stall/reset sequences and random commands vs. an arithmetic model.
module tb_up_dn_cmd_driver;
   localparam int WIDTH = 5;
   localparam int CNT_W = 8;
   localparam int MAXV  = (1 << WIDTH) - 1;

   logic             CLK = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_val;
   logic [CNT_W-1:0] cmd_rep;
   logic             High, Low;
   logic [WIDTH-1:0] IN;
   logic             load, Up, Down, busy, done, sat;
   logic [CNT_W-1:0] done_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   up_dn_cmd_driver #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_val(cmd_val), .cmd_rep(cmd_rep),
      .High(High), .Low(Low), .IN(IN), .load(load), .Up(Up), .Down(Down),
      .busy(busy), .done(done), .sat(sat), .done_cnt(done_cnt)
   );

   // Emulated counter; it is deliberately not tied to rst.
   logic [WIDTH-1:0] ctr = '0;
   always @(posedge CLK) begin
      if (load)      ctr <= IN;
      else if (Up)   ctr <= ctr + 1'b1;
      else if (Down) ctr <= ctr - 1'b1;
   end
   assign High = (ctr == WIDTH'(MAXV));
   assign Low  = (ctr == '0);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Outcome of one command from the counter value alone.
   task automatic predict(input int op, input int v, input int rep, input int cur,
                          output int lat, output int dc, output int s, output int nxt);
      int room;
      lat = 0; dc = 0; s = 0; nxt = cur;
      if (op == 0) begin
         lat = 2; nxt = v;
      end else if (op == 3) begin
         lat = rep + 1;
      end else begin
         room = (op == 1) ? (MAXV - cur) : cur;
         if (rep == 0) begin
            lat = 1;
         end else if (rep <= room) begin
            dc = rep; lat = rep + 1;
         end else begin
            dc = room; lat = room + 2; s = 1;
         end
         nxt = (op == 1) ? cur + dc : cur - dc;
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] v, input logic [CNT_W-1:0] r,
                       output int lat, output int pulses, output int s, output int dc);
      int w;
      lat = -1; pulses = 0; s = 0; dc = 0;
      @(negedge CLK);
      cmd_valid = 1'b1; cmd_op = op; cmd_val = v; cmd_rep = r;
      w = 0;
      while (!cmd_ready && w < 100) begin
         @(negedge CLK);
         w++;
      end
      if (!cmd_ready) begin
         check("accept_timeout", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      @(negedge CLK);
      cmd_valid = 1'b0;
      for (int i = 1; i <= 300; i++) begin
         if (i > 1) @(negedge CLK);
         check("strobe_exclusive", 32'(int'(load) + int'(Up) + int'(Down) <= 1), 1);
         check("up_gated_by_high", 32'(Up & High), 0);
         check("down_gated_by_low", 32'(Down & Low), 0);
         check("ready_low_while_busy", 32'(cmd_ready), 0);
         if (load) check("load_IN", 32'(IN), 32'(v));
         if (Up || Down) pulses++;
         if (done) begin
            lat = i; s = int'(sat); dc = int'(done_cnt);
            break;
         end
      end
      if (lat < 0) check("done_timeout", 0, 1);
   endtask

   typedef struct {
      logic [1:0]       op;
      logic [WIDTH-1:0] val;
      logic [CNT_W-1:0] rep;
      int               lat;
      int               dc;
      int               sat;
      int               cnt;
   } vec_t;

   vec_t vecs[16];

   initial begin
      int lat, pulses, s, dc;
      int e_lat, e_dc, e_s, e_nxt;
      int acci, donei, loadi, lowcnt, badstrobe, npulse;

      vecs[0]  = '{2'd0, 5'd9,  8'd0,   2,  0, 0, 9};
      vecs[1]  = '{2'd2, 5'd0,  8'd4,   5,  4, 0, 5};
      vecs[2]  = '{2'd1, 5'd0,  8'd40,  28, 26, 1, 31};
      vecs[3]  = '{2'd1, 5'd0,  8'd3,   2,  0, 1, 31};
      vecs[4]  = '{2'd2, 5'd0,  8'd0,   1,  0, 0, 31};
      vecs[5]  = '{2'd3, 5'd0,  8'd3,   4,  0, 0, 31};
      vecs[6]  = '{2'd0, 5'd0,  8'd0,   2,  0, 0, 0};
      vecs[7]  = '{2'd2, 5'd0,  8'd5,   2,  0, 1, 0};
      vecs[8]  = '{2'd1, 5'd0,  8'd1,   2,  1, 0, 1};
      vecs[9]  = '{2'd2, 5'd0,  8'd1,   2,  1, 0, 0};
      vecs[10] = '{2'd0, 5'd30, 8'd0,   2,  0, 0, 30};
      vecs[11] = '{2'd1, 5'd0,  8'd1,   2,  1, 0, 31};
      vecs[12] = '{2'd1, 5'd0,  8'd0,   1,  0, 0, 31};
      vecs[13] = '{2'd0, 5'd3,  8'd0,   2,  0, 0, 3};
      vecs[14] = '{2'd2, 5'd0,  8'd3,   4,  3, 0, 0};
      vecs[15] = '{2'd0, 5'd31, 8'd255, 2,  0, 0, 31};

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_val = '0; cmd_rep = '0;
      repeat (2) @(negedge CLK);
      check("reset_outputs_zero",
            32'({cmd_ready, load, Up, Down, busy, done, sat, IN, done_cnt}), 0);
      rst = 1'b0;
      @(negedge CLK);
      check("ready_after_reset", 32'(cmd_ready), 1);
      check("busy_after_reset", 32'(busy), 0);
      check("IN_after_reset", 32'(IN), 0);

      for (int k = 0; k < 16; k++) begin
         send(vecs[k].op, vecs[k].val, vecs[k].rep, lat, pulses, s, dc);
         check("vec_latency", 32'(lat), 32'(vecs[k].lat));
         check("vec_done_cnt", 32'(dc), 32'(vecs[k].dc));
         check("vec_sat", 32'(s), 32'(vecs[k].sat));
         check("vec_pulses", 32'(pulses), 32'(vecs[k].dc));
         check("vec_counter", 32'(ctr), 32'(vecs[k].cnt));
         @(negedge CLK);
         check("vec_ready_after_done", 32'(cmd_ready), 1);
      end
      send(2'd2, 5'd0, 8'd255, lat, pulses, s, dc);
      check("down_full_latency", 32'(lat), 33);
      check("down_full_cnt", 32'(dc), 31);
      check("down_full_sat", 32'(s), 1);
      check("down_full_counter", 32'(ctr), 0);

      // HOLD 3 with the next command (LOAD 5) stalled behind it.
      @(negedge CLK);
      cmd_valid = 1'b1; cmd_op = 2'd3; cmd_val = '0; cmd_rep = 8'd3;
      check("hold_ready_at_accept", 32'(cmd_ready), 1);
      acci = -1; donei = -1; loadi = -1; lowcnt = 0; badstrobe = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge CLK);
         if (i == 1) begin
            cmd_op = 2'd0; cmd_val = 5'd5; cmd_rep = '0;
         end
         if (acci > 0 && i == acci + 1) cmd_valid = 1'b0;
         if (cmd_ready && acci < 0) acci = i;
         if (!cmd_ready && acci < 0) lowcnt++;
         if (done && donei < 0) donei = i;
         if (load) begin
            loadi = i;
            check("stall_load_IN", 32'(IN), 5);
         end
         if (i <= 4 && (load || Up || Down)) badstrobe++;
      end
      check("hold_done_cycle", 32'(donei), 4);
      check("hold_ready_low_cycles", 32'(lowcnt), 4);
      check("hold_no_strobes", 32'(badstrobe), 0);
      check("stalled_accept_cycle", 32'(acci), 5);
      check("stalled_load_cycle", 32'(loadi), 6);
      check("stalled_counter", 32'(ctr), 5);

      // Abort a DOWN command with rst after three pulses.
      send(2'd0, 5'd20, 8'd0, lat, pulses, s, dc);
      check("pre_abort_counter", 32'(ctr), 20);
      @(negedge CLK);
      cmd_valid = 1'b1; cmd_op = 2'd2; cmd_rep = 8'd20;
      check("abort_ready_at_accept", 32'(cmd_ready), 1);
      npulse = 0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge CLK);
         cmd_valid = 1'b0;
         if (Down) npulse++;
      end
      check("abort_pulses_before_rst", 32'(npulse), 3);
      @(negedge CLK);
      rst = 1'b1;
      #1;
      check("abort_outputs_zero",
            32'({cmd_ready, load, Up, Down, busy, done, sat, IN, done_cnt}), 0);
      @(negedge CLK);
      rst = 1'b0;
      #1;
      check("abort_ready_after_release", 32'(cmd_ready), 1);
      check("abort_no_done", 32'(done), 0);
      check("abort_not_busy", 32'(busy), 0);
      check("abort_counter_kept", 32'(ctr), 17);
      send(2'd1, 5'd0, 8'd2, lat, pulses, s, dc);
      check("post_abort_latency", 32'(lat), 3);
      check("post_abort_cnt", 32'(dc), 2);
      check("post_abort_counter", 32'(ctr), 19);

      for (int k = 0; k < 40; k++) begin
         logic [1:0]       rop;
         logic [WIDTH-1:0] rv;
         logic [CNT_W-1:0] rr;
         rop = 2'($urandom_range(0, 3));
         rv  = WIDTH'($urandom);
         rr  = CNT_W'($urandom_range(0, 45));
         predict(int'(rop), int'(rv), int'(rr), int'(ctr), e_lat, e_dc, e_s, e_nxt);
         send(rop, rv, rr, lat, pulses, s, dc);
         check("rand_latency", 32'(lat), 32'(e_lat));
         check("rand_done_cnt", 32'(dc), 32'(e_dc));
         check("rand_sat", 32'(s), 32'(e_s));
         check("rand_pulses", 32'(pulses), 32'(e_dc));
         check("rand_counter", 32'(ctr), 32'(e_nxt));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
